// File: rtl/pueo_rdsched_pkg.sv
// Shared definitions for the PUEO readout scheduler.
//   - state_t   : scheduler FSM states (IDLE/ARM/READ/COMMIT)
//   - idx_w()   : index width for a count of n items (at least 1 bit)
//   - addr_t / chan_t / slot_t / beat_t : widths for the default build
//     (NCHAN=8, ADDRLEN=14, RDLEN=1024, NBUF=8)
package pueo_rdsched_pkg;

  localparam int unsigned DEF_NCHAN   = 8;
  localparam int unsigned DEF_ADDRLEN = 14;
  localparam int unsigned DEF_RDLEN   = 1024;
  localparam int unsigned DEF_NBUF    = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter spans one channel's worth of words.
  localparam int unsigned DEF_BEAT_W = idx_w(DEF_RDLEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_READ   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  typedef logic [DEF_ADDRLEN-1:0]        addr_t;
  typedef logic [idx_w(DEF_NCHAN)-1:0]   chan_t;
  typedef logic [idx_w(DEF_NBUF)-1:0]    slot_t;
  typedef logic [DEF_BEAT_W-1:0]         beat_t;

endpackage

// File: rtl/pueo_buf_alloc.sv
// Event-buffer slot allocator.
// Keeps one occupancy bit per slot, offers the lowest-index free slot and
// a registered "all slots occupied" flag.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (clears all occupancy)
//   i_set/i_set_idx mark a slot occupied
//   i_clr/i_clr_idx mark a slot free (freeing a free slot has no effect)
//   o_free_idx      lowest-index free slot, from current (pre-update) occupancy
//   o_any_free      at least one slot free, from current occupancy
//   o_full          all slots occupied, registered
module pueo_buf_alloc
  import pueo_rdsched_pkg::*;
#(
  parameter int NBUF = 8,
  parameter int IW   = idx_w(NBUF)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_set,
  input  logic [IW-1:0] i_set_idx,
  input  logic          i_clr,
  input  logic [IW-1:0] i_clr_idx,
  output logic [IW-1:0] o_free_idx,
  output logic          o_any_free,
  output logic          o_full
);

  logic [NBUF-1:0] r_occ;
  logic [NBUF-1:0] w_occ_nxt;
  logic            r_full;

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    o_free_idx = '0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (!r_occ[i]) o_free_idx = IW'(i);
    end
  end

  // Set is applied after clear: a slot being allocated was free already, so
  // a coincident free of that same slot must not undo the allocation.
  always_comb begin
    w_occ_nxt = r_occ;
    if (i_clr) w_occ_nxt[i_clr_idx] = 1'b0;
    if (i_set) w_occ_nxt[i_set_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= '0;
      r_full <= 1'b0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_full <= &w_occ_nxt;
    end
  end

  assign o_any_free = ~&r_occ;
  assign o_full     = r_full;

endmodule

// File: rtl/pueo_readout_sched.sv
// Trigger-driven readout scheduler (memclk domain).
// Accepts a trigger time, allocates the lowest free event-buffer slot,
// computes the lookback start address and streams NCHAN x RDLEN read beats
// into that slot, then pulses evt_valid_o to hand the slot to the ifclk side.
// Ports:
//   memclk_i, memclk_rstn_i       clock, async active-low reset
//   trig_time_i/valid_i/ready_o   trigger handshake (accepted only in IDLE)
//   offset_i                      lookback offset, held static during READ
//   rd_en_o/addr_o/chan_o/buf_o/last_o  read beat stream
//   evt_valid_o/evt_buf_o         1-cycle slot commit
//   buf_done_i/buf_done_idx_i     slot release from the ifclk side
//   buf_full_o                    all slots occupied (registered)
//   busy_o                        FSM not IDLE
//   drop_count_o                  dropped-trigger counter
// Build option: PUEO_RDSCHED_DROPCNT_EN adds drop_count_o, a saturating
// 16-bit count of triggers accepted while no slot was free. Without it the
// port is absent and such triggers are dropped silently.
module pueo_readout_sched
  import pueo_rdsched_pkg::*;
#(
  parameter int NCHAN    = 8,
  parameter int ADDRLEN  = 14,
  parameter int TRIGBITS = 15,
  parameter int RDLEN    = 1024,
  parameter int NBUF     = 8
) (
  input  logic                     memclk_i,
  input  logic                     memclk_rstn_i,
  input  logic [TRIGBITS-1:0]      trig_time_i,
  input  logic                     trig_valid_i,
  output logic                     trig_ready_o,
  input  logic [ADDRLEN-1:0]       offset_i,
  output logic                     rd_en_o,
  output logic [ADDRLEN-1:0]       rd_addr_o,
  output logic [idx_w(NCHAN)-1:0]  rd_chan_o,
  output logic [idx_w(NBUF)-1:0]   rd_buf_o,
  output logic                     rd_last_o,
  output logic                     evt_valid_o,
  output logic [idx_w(NBUF)-1:0]   evt_buf_o,
  input  logic                     buf_done_i,
  input  logic [idx_w(NBUF)-1:0]   buf_done_idx_i,
  output logic                     buf_full_o,
  output logic                     busy_o
`ifdef PUEO_RDSCHED_DROPCNT_EN
  ,
  output logic [15:0]              drop_count_o
`endif
);

  localparam int CHW = idx_w(NCHAN);
  localparam int SLW = idx_w(NBUF);
  localparam int BW  = idx_w(RDLEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDRLEN-1:0]  r_trig;
  logic [ADDRLEN-1:0]  r_start;
  logic [ADDRLEN-1:0]  r_addr;
  logic [BW-1:0]       r_beat;
  logic [CHW-1:0]      r_chan;
  logic [SLW-1:0]      r_slot;

  logic [SLW-1:0]      w_free_idx;
  logic                w_any_free;
  logic                w_full;
  logic                w_accept;
  logic                w_beat_last;
  logic                w_chan_last;

  // Only the low ADDRLEN bits of the trigger time address the lookback.
  logic                w_unused_trig_hi;
  assign w_unused_trig_hi = ^trig_time_i[TRIGBITS-1:ADDRLEN];

  assign w_accept    = (r_state == ST_IDLE) && trig_valid_i && w_any_free;
  assign w_beat_last = (r_beat == BW'(RDLEN - 1));
  assign w_chan_last = (r_chan == CHW'(NCHAN - 1));

  pueo_buf_alloc #(
    .NBUF (NBUF),
    .IW   (SLW)
  ) u_alloc (
    .i_clk      (memclk_i),
    .i_rst_n    (memclk_rstn_i),
    .i_set      (r_state == ST_ARM),
    .i_set_idx  (w_free_idx),
    .i_clr      (buf_done_i),
    .i_clr_idx  (buf_done_idx_i),
    .o_free_idx (w_free_idx),
    .o_any_free (w_any_free),
    .o_full     (w_full)
  );

  // State register
  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_ARM;
      ST_ARM:    w_state_nxt = ST_READ;
      ST_READ:   if (w_beat_last && w_chan_last) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: outputs are gated by state so stale sequencing registers
  // never leak onto the ports outside their phase.
  always_comb begin
    trig_ready_o = 1'b0;
    rd_en_o      = 1'b0;
    rd_addr_o    = '0;
    rd_chan_o    = '0;
    rd_buf_o     = '0;
    rd_last_o    = 1'b0;
    evt_valid_o  = 1'b0;
    evt_buf_o    = '0;
    case (r_state)
      ST_IDLE: trig_ready_o = 1'b1;
      ST_READ: begin
        rd_en_o   = 1'b1;
        rd_addr_o = r_addr;
        rd_chan_o = r_chan;
        rd_buf_o  = r_slot;
        rd_last_o = w_beat_last;
      end
      ST_COMMIT: begin
        evt_valid_o = 1'b1;
        evt_buf_o   = r_slot;
      end
      default: ;
    endcase
  end

  assign busy_o     = (r_state != ST_IDLE);
  assign buf_full_o = w_full;

  // Trigger time and start address are pure data: captured, never reset.
  always_ff @(posedge memclk_i) begin
    if (w_accept)            r_trig  <= trig_time_i[ADDRLEN-1:0];
    if (r_state == ST_ARM)   r_start <= r_trig - offset_i;
  end

  // Beat sequencing. Address wraps naturally at 2^ADDRLEN; every channel
  // re-reads the same lookback window starting from r_start.
  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      r_addr <= '0;
      r_beat <= '0;
      r_chan <= '0;
      r_slot <= '0;
    end else begin
      case (r_state)
        ST_ARM: begin
          r_addr <= r_trig - offset_i;
          r_beat <= '0;
          r_chan <= '0;
          r_slot <= w_free_idx;
        end
        ST_READ: begin
          if (w_beat_last) begin
            r_beat <= '0;
            r_addr <= r_start;
            r_chan <= r_chan + 1'b1;
          end else begin
            r_beat <= r_beat + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PUEO_RDSCHED_DROPCNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A trigger seen in IDLE with every slot occupied is consumed and dropped.
  assign w_drop = (r_state == ST_IDLE) && trig_valid_i && !w_any_free;

  always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i)                          r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pueo_readout_sched.sv
// Testbench for pueo_readout_sched (default parameters).
// A behavioural model tracks time since trigger acceptance, slot occupancy
// and drops, and every output is compared to it on each falling edge.
// Directed literal checks pin the model to hand-computed addresses/slots.
module tb_pueo_readout_sched;

  localparam int NCHAN = 8;
  localparam int RDLEN = 1024;
  localparam int NBUF  = 8;
  localparam int NBEAT = NCHAN * RDLEN;

  logic        clk;
  logic        rstn;
  logic [14:0] trig_time;
  logic        trig_valid;
  logic        trig_ready;
  logic [13:0] offset;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [2:0]  rd_chan;
  logic [2:0]  rd_buf;
  logic        rd_last;
  logic        evt_valid;
  logic [2:0]  evt_buf;
  logic        buf_done;
  logic [2:0]  buf_done_idx;
  logic        buf_full;
  logic        busy;
`ifdef PUEO_RDSCHED_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pueo_readout_sched dut (
    .memclk_i       (clk),
    .memclk_rstn_i  (rstn),
    .trig_time_i    (trig_time),
    .trig_valid_i   (trig_valid),
    .trig_ready_o   (trig_ready),
    .offset_i       (offset),
    .rd_en_o        (rd_en),
    .rd_addr_o      (rd_addr),
    .rd_chan_o      (rd_chan),
    .rd_buf_o       (rd_buf),
    .rd_last_o      (rd_last),
    .evt_valid_o    (evt_valid),
    .evt_buf_o      (evt_buf),
    .buf_done_i     (buf_done),
    .buf_done_idx_i (buf_done_idx),
    .buf_full_o     (buf_full),
    .busy_o         (busy)
`ifdef PUEO_RDSCHED_DROPCNT_EN
    ,
    .drop_count_o   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t: cycles since acceptance (-1 = idle). t=0 arm, t=1..NBEAT beats,
  // t=NBEAT+1 commit.
  int          m_t = -1;
  logic [13:0] m_trig;
  logic [13:0] m_start;
  int          m_slot = 0;
  logic [7:0]  m_occ = '0;
  int          m_drops = 0;
  int          beats_seen = 0;

  always @(negedge clk) begin
    logic [28:0] e_vec, g_vec;
    logic [7:0]  nocc;
    logic [13:0] e_addr;
    logic [2:0]  e_chan, e_buf, e_ebuf;
    logic        e_rd, e_last, e_evt;
    int k;

    if (!rstn) begin
      m_t = -1; m_occ = '0; m_drops = 0; beats_seen = 0;
    end

    e_rd = (m_t >= 1) && (m_t <= NBEAT);
    e_addr = '0; e_chan = '0; e_buf = '0; e_last = 1'b0;
    if (e_rd) begin
      k      = m_t - 1;
      e_addr = 14'(int'(m_start) + (k % RDLEN));
      e_chan = 3'(k / RDLEN);
      e_buf  = 3'(m_slot);
      e_last = ((k % RDLEN) == RDLEN - 1);
    end
    e_evt  = (m_t == NBEAT + 1);
    e_ebuf = e_evt ? 3'(m_slot) : 3'd0;
    e_vec = {(m_t < 0), (m_t >= 0), e_rd, e_addr, e_chan, e_buf, e_last, e_evt, e_ebuf, (m_occ == 8'hFF)};
    g_vec = {trig_ready, busy, rd_en, rd_addr, rd_chan, rd_buf, rd_last, evt_valid, evt_buf, buf_full};
    n_tests++;
    if (g_vec !== e_vec) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0d: got %b required %b (ready busy rd addr chan buf last evt ebuf full)",
               m_t, g_vec, e_vec);
    end
`ifdef PUEO_RDSCHED_DROPCNT_EN
    n_tests++;
    if (drop_count !== 16'(m_drops)) begin
      n_fail++;
      $display("FAIL drop_count: got %0d required %0d", drop_count, m_drops);
    end
`endif
    if (rd_en === 1'b1) beats_seen++;
    if (evt_valid === 1'b1) begin
      n_tests++;
      if (beats_seen != 8192) begin
        n_fail++;
        $display("FAIL beat_total: got %0d required 8192", beats_seen);
      end
      beats_seen = 0;
    end

    // advance model with this cycle's inputs
    if (rstn) begin
      nocc = m_occ;
      if (buf_done) nocc[buf_done_idx] = 1'b0;
      if (m_t < 0) begin
        if (trig_valid) begin
          if (m_occ != 8'hFF) begin
            m_t = 0;
            m_trig = trig_time[13:0];
          end else if (m_drops < 65535) begin
            m_drops++;
          end
        end
      end else if (m_t == 0) begin
        m_start = m_trig - offset;
        for (int i = NBUF - 1; i >= 0; i--) if (!m_occ[i]) m_slot = i;
        nocc[m_slot] = 1'b1;
        m_t = 1;
      end else if (m_t == NBEAT + 1) begin
        m_t = -1;
      end else begin
        m_t++;
      end
      m_occ = nocc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_trig(input logic [14:0] t);
    @(posedge clk); #1;
    trig_time  = t;
    trig_valid = 1'b1;
    @(posedge clk); #1;
    trig_valid = 1'b0;
  endtask

  task automatic wait_evt(input int exp_buf);
    int n = 0;
    while (evt_valid !== 1'b1 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (n >= 9000) begin
      n_tests++; n_fail++;
      $display("FAIL evt_timeout: got no evt_valid within 9000 cycles, required one");
    end else begin
      chk("evt_buf", 32'(evt_buf), 32'(exp_buf));
    end
  endtask

  initial begin
    int fidx;
    rstn = 1'b0; trig_valid = 1'b0; trig_time = '0; offset = '0;
    buf_done = 1'b0; buf_done_idx = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(trig_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_full",  32'(buf_full), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Reset asserted in the middle of channel 4: read aborted, no commit.
    offset = 14'h0040;
    pulse_trig(15'h0100);
    @(posedge clk); #1;
    chk("abort_first_addr", 32'(rd_addr), 32'h00C0);
    repeat (4106) @(posedge clk);
    #1;
    chk("abort_chan4", 32'(rd_chan), 4);
    rstn = 1'b0;
    #1;
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_busy",  32'(busy), 0);
    chk("abort_addr",  32'(rd_addr), 0);
    chk("abort_ready", 32'(trig_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (10) @(posedge clk);

    // Event 1: start 0x0100-0x0040 = 0x00C0, slot 0 after the reset.
    pulse_trig(15'h0100);
    @(posedge clk); #1;
    chk("e1_rd_en", 32'(rd_en), 1);
    chk("e1_addr",  32'(rd_addr), 32'h00C0);
    chk("e1_chan",  32'(rd_chan), 0);
    chk("e1_buf",   32'(rd_buf), 0);
    wait_evt(0);

    // Event 2: start wraps below zero to 0x3FD0.
    pulse_trig(15'h0010);
    @(posedge clk); #1;
    chk("e2_start", 32'(rd_addr), 32'h3FD0);
    repeat (48) @(posedge clk);
    #1;
    chk("e2_beat48_addr", 32'(rd_addr), 32'h0000);
    repeat (975) @(posedge clk);
    #1;
    chk("e2_last",      32'(rd_last), 1);
    chk("e2_last_addr", 32'(rd_addr), 32'h03CF);
    chk("e2_last_chan", 32'(rd_chan), 0);
    @(posedge clk); #1;
    chk("e2_ch1_chan", 32'(rd_chan), 1);
    chk("e2_ch1_addr", 32'(rd_addr), 32'h3FD0);
    chk("e2_ch1_last", 32'(rd_last), 0);
    wait_evt(1);

    // Event 3: upper trigger bit ignored.
    pulse_trig(15'h4100);
    @(posedge clk); #1;
    chk("e3_addr", 32'(rd_addr), 32'h00C0);
    chk("e3_buf",  32'(rd_buf), 2);
    wait_evt(2);

    // Events 4..8: random times/offsets, random gaps, spurious frees of free slots.
    for (int e = 3; e < NBUF; e++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) begin
        fidx = 0;
        for (int i = 0; i < NBUF; i++) if (!m_occ[i]) fidx = i;
        @(posedge clk); #1;
        buf_done = 1'b1; buf_done_idx = 3'(fidx);
        @(posedge clk); #1;
        buf_done = 1'b0;
      end
      offset = 14'($urandom);
      pulse_trig(15'($urandom));
      wait_evt(e);
    end
    chk("full_after_8", 32'(buf_full), 1);

    // 9th trigger with every slot occupied: dropped.
    pulse_trig(15'($urandom));
    repeat (3) @(posedge clk);
    #1;
    chk("drop_busy",  32'(busy), 0);
    chk("drop_rd_en", 32'(rd_en), 0);
`ifdef PUEO_RDSCHED_DROPCNT_EN
    chk("drop_count_1", 32'(drop_count), 1);
`endif

    // Free slot 3 in IDLE, trigger on the next cycle takes slot 3.
    offset = 14'h0040;
    @(posedge clk); #1;
    buf_done = 1'b1; buf_done_idx = 3'd3;
    @(posedge clk); #1;
    buf_done = 1'b0;
    trig_time = 15'h0100; trig_valid = 1'b1;
    @(posedge clk); #1;
    trig_valid = 1'b0;
    wait_evt(3);

    // Trigger coincident with freeing slot 5: occupancy before the free is full, so dropped.
    @(posedge clk); #1;
    buf_done = 1'b1; buf_done_idx = 3'd5;
    trig_time = 15'h0200; trig_valid = 1'b1;
    @(posedge clk); #1;
    buf_done = 1'b0; trig_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("coinc_busy", 32'(busy), 0);
    chk("coinc_full", 32'(buf_full), 0);
`ifdef PUEO_RDSCHED_DROPCNT_EN
    chk("drop_count_2", 32'(drop_count), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
